// File: rtl/tx_7seg_scan_driver.sv
// Time-multiplexed hex display driver: latches a packed hex word and scans it
// digit by digit onto a shared segment bus, with tear-free frame-aligned updates.
module tx_7seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] hex_lit(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b0111111;
      4'h1: p = 7'b0000110;
      4'h2: p = 7'b1011011;
      4'h3: p = 7'b1001111;
      4'h4: p = 7'b1100110;
      4'h5: p = 7'b1101101;
      4'h6: p = 7'b1111101;
      4'h7: p = 7'b0000111;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1101111;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b1111100;
      4'hC: p = 7'b0111001;
      4'hD: p = 7'b1011110;
      4'hE: p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [DATA_W-1:0]     shadow_nib_q, shadow_nib_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DATA_W-1:0]     disp_nib_q, disp_nib_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q;

  logic                  step, wrap;
  logic                  zero_above, cur_blank, cur_dp;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_lit;
  logic [NUM_DIGITS-1:0] an_hot;

  assign step = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign wrap = step && (dig_idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    div_cnt_d    = step ? '0 : div_cnt_q + 1'b1;
    dig_idx_d    = dig_idx_q;
    shadow_nib_d = shadow_nib_q;
    shadow_dp_d  = shadow_dp_q;
    disp_nib_d   = disp_nib_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (step) begin
      dig_idx_d = wrap ? '0 : dig_idx_q + 1'b1;
    end
    // Display contents only change on a frame boundary so no frame mixes words.
    if (wrap) begin
      if (load) begin
        disp_nib_d = data_in;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_nib_d = shadow_nib_q;
        disp_dp_d  = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_nib_d = data_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
  end

  always_comb begin
    zero_above = 1'b1;
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    an_hot     = '0;
    // Walk from the most significant digit so zero_above covers digits N-1..k.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (disp_nib_q[4*k +: 4] == 4'h0);
      if (dig_idx_q == IDX_W'(k)) begin
        cur_nib   = disp_nib_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = blank_lz && zero_above && (k != 0);
        an_hot[k] = 1'b1;
      end
    end
    seg_lit = cur_blank ? 7'h00 : hex_lit(cur_nib);
    seg_d   = (SEG_ACT_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d    = (SEG_ACT_LOW != 0) ? ~cur_dp : cur_dp;
    an_d    = (AN_ACT_LOW != 0) ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      shadow_nib_q <= '0;
      shadow_dp_q  <= '0;
      disp_nib_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      tick_q       <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_nib_q   <= disp_nib_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      tick_q       <= wrap;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_tx_7seg_scan_driver.sv
// Randomized bench for tx_7seg_scan_driver with a cycle-count based reference
// model plus literal spot checks of the scan, decode, blanking and reset behaviour.
module tb_tx_7seg_scan_driver;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int FR = N * CD;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  data_in = '0;
  logic [3:0]   dp_in = '0;
  logic         blank_lz = 1'b0;
  logic [6:0]   seg_out;
  logic         dp_out;
  logic [3:0]   an_out;
  logic         frame_tick;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  tx_7seg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Lit gfedcba patterns for hex digits 0..F.
  logic [6:0] LIT [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  int          m;
  logic [15:0] mdisp, mshadow;
  logic [3:0]  mdp, mshadow_dp;
  bit          mpend;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_tick;
  logic [3:0]  exp_an;

  // Reference model: m counts clock edges since reset release; the scan
  // position and frame boundaries follow from it arithmetically.
  initial begin
    int dig;
    logic [3:0] nib;
    bit blank;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m = 0; mdisp = '0; mdp = '0; mshadow = '0; mshadow_dp = '0; mpend = 0;
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_tick = 1'b0;
      end else begin
        dig      = (m / CD) % N;
        nib      = mdisp[dig*4 +: 4];
        blank    = blank_lz && (dig != 0) && ((mdisp >> (dig*4)) == 16'h0);
        exp_seg  = blank ? 7'h7F : ~LIT[nib];
        exp_dp   = ~mdp[dig];
        exp_an   = ~(4'b0001 << dig);
        exp_tick = ((m % FR) == FR - 1);
        if ((m % FR) == FR - 1) begin
          if (load) begin
            mdisp = data_in; mdp = dp_in;
          end else if (mpend) begin
            mdisp = mshadow; mdp = mshadow_dp;
          end
          mpend = 0;
        end else if (load) begin
          mshadow = data_in; mshadow_dp = dp_in; mpend = 1;
        end
        m++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an ||
            frame_tick !== exp_tick) begin
          errors++;
          $display("FAIL model_cmp t=%0t seg got %b exp %b, dp got %b exp %b, an got %b exp %b, tick got %b exp %b",
                   $time, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an, frame_tick, exp_tick);
        end
      end
    end
  end

  task automatic lit_chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    if (frame_tick !== 1'b1) begin
      vectors++;
      errors++;
      $display("FAIL wait_tick got no frame_tick within %0d cycles exp pulse", n);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    cyc(3);
    lit_chk("rst_seg", {9'd0, seg_out}, 16'h007F);
    lit_chk("rst_an", {12'd0, an_out}, 16'h000F);
    rst = 1'b0;
    // Scan timing after reset release.
    cyc(1);
    lit_chk("first_seg", {9'd0, seg_out}, 16'h0040);
    lit_chk("first_an", {12'd0, an_out}, 16'h000E);
    cyc(3);
    lit_chk("dig0_hold", {12'd0, an_out}, 16'h000E);
    cyc(1);
    lit_chk("dig1_an", {12'd0, an_out}, 16'h000D);
    cyc(11);
    lit_chk("tick16", {15'd0, frame_tick}, 16'h0001);
    lit_chk("tick16_an", {12'd0, an_out}, 16'h0007);

    // Mid-frame load appears only from the next frame.
    cyc(5);
    data_in = 16'h12AF; load = 1'b1;
    cyc(1);
    load = 1'b0;
    lit_chk("old_shown", {9'd0, seg_out}, 16'h0040);
    wait_tick();
    cyc(1);
    lit_chk("d0_F", {9'd0, seg_out}, 16'h000E);
    cyc(4);
    lit_chk("d1_A", {9'd0, seg_out}, 16'h0008);
    cyc(4);
    lit_chk("d2_2", {9'd0, seg_out}, 16'h0024);
    cyc(4);
    lit_chk("d3_1", {9'd0, seg_out}, 16'h0079);

    // Two loads in one frame: last wins.
    data_in = 16'h1111; load = 1'b1;
    cyc(1);
    data_in = 16'h2222;
    cyc(1);
    load = 1'b0;
    wait_tick();
    cyc(1);
    lit_chk("last_wins", {9'd0, seg_out}, 16'h0024);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    data_in = 16'h0050; load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_tick();
    cyc(1);
    lit_chk("lz_d0", {9'd0, seg_out}, 16'h0040);
    cyc(4);
    lit_chk("lz_d1", {9'd0, seg_out}, 16'h0012);
    cyc(4);
    lit_chk("lz_d2", {9'd0, seg_out}, 16'h007F);
    data_in = 16'h0000; load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_tick();
    cyc(1);
    lit_chk("zero_d0", {9'd0, seg_out}, 16'h0040);
    cyc(4);
    lit_chk("zero_d1", {9'd0, seg_out}, 16'h007F);

    // Load on the wrap cycle applies to the frame that starts right then.
    blank_lz = 1'b0;
    wait_tick();
    cyc(15);
    data_in = 16'h0003; dp_in = 4'b0100; load = 1'b1;
    cyc(1);
    load = 1'b0;
    lit_chk("wrap_tick", {15'd0, frame_tick}, 16'h0001);
    cyc(1);
    lit_chk("wrap_d0", {9'd0, seg_out}, 16'h0030);
    lit_chk("wrap_dp0", {15'd0, dp_out}, 16'h0001);
    cyc(8);
    lit_chk("dp2_an", {12'd0, an_out}, 16'h000B);
    lit_chk("dp2", {15'd0, dp_out}, 16'h0000);

    // Reset with a load pending.
    data_in = 16'h8888; dp_in = 4'hF; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    rst = 1'b1;
    #1;
    lit_chk("mid_rst_seg", {9'd0, seg_out}, 16'h007F);
    lit_chk("mid_rst_an", {12'd0, an_out}, 16'h000F);
    lit_chk("mid_rst_dp", {15'd0, dp_out}, 16'h0001);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    lit_chk("post_rst", {9'd0, seg_out}, 16'h0040);
    wait_tick();
    cyc(1);
    lit_chk("pend_lost", {9'd0, seg_out}, 16'h0040);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(7) == 0);
      for (int k = 0; k < 4; k++)
        data_in[k*4 +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      dp_in = 4'($urandom_range(15));
      if ($urandom_range(63) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(999) == 0) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
      cyc(1);
    end
    load = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
